instr_stim_gen: RTL
===================

INSTR_STIM_GEN -- requirements
Module: instr_stim_gen

Interface
REQ-001 SHALL have parameter SEED, default 32'd1016, LFSR seed; a value of 0 is replaced by 1.
REQ-002 SHALL have parameter NUM_INSTR, default 100, number of random instructions per run (0 allowed).
REQ-003 SHALL have parameter NOP_FLUSH, default 4, number of NOP beats issued before random instructions.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a run; honoured only in IDLE.
REQ-007 SHALL have port out_valid  output  1  out_instr holds a beat for the core's imem response.
REQ-008 SHALL have port out_ready  input  1  core accepts the beat; a beat transfers when out_valid && out_ready.
REQ-009 SHALL have port out_instr  output  32  RV32I instruction word, registered.
REQ-010 SHALL have port out_is_load  output  1  high when out_instr[6:0] == 7'b0000011.
REQ-011 SHALL have port done  output  1  sticky run-complete flag.
REQ-012 SHALL have port count  output  16  number of random (RUN) beats transferred, saturating at 16'hFFFF.

Function
REQ-013 SHALL implement FSM states IDLE, FLUSH, RUN, DONE.
REQ-014 IDLE: out_valid=0, out_instr=32'h00000013; start=1 -> FLUSH (-> RUN if NOP_FLUSH=0; -> DONE if both NOP_FLUSH=0 and NUM_INSTR=0).
REQ-015 FLUSH: out_valid=1, out_instr=32'h00000013; after NOP_FLUSH transfers -> RUN, or -> DONE if NUM_INSTR=0.
REQ-016 SHALL use a 32-bit Galois LFSR with polynomial x^32+x^22+x^2+x+1 (taps 32'h80200003); it advances exactly once per load of a random word.
REQ-017 Field extraction from the current LFSR value L: il_choice=L[0], rd=L[5:1], rs1=L[10:6], funct3=L[13:11], imm=L[25:14], funct3_l={L[26],2'b00}, imm_l=L[31:20].
REQ-018 Shift masking: funct3=5 -> imm &= 12'h41F; funct3=1 -> imm &= 12'h01F.
REQ-019 Encoding: il_choice=1 -> {imm,rs1,funct3,rd,7'b0010011}; il_choice=0 -> {imm_l,rs1,funct3_l,rd,7'b0000011}.
REQ-020 A random word SHALL be loaded into out_instr, and the LFSR advanced, on the last FLUSH transfer (or on the start cycle when NOP_FLUSH=0) and on every RUN transfer that does not complete the run.
REQ-021 While out_valid && !out_ready, out_instr, out_valid, LFSR and count SHALL hold unchanged.
REQ-022 Each RUN transfer SHALL increment count; the transfer that makes count == NUM_INSTR -> DONE in the next cycle.
REQ-023 DONE: out_valid=0, out_instr=32'h00000013, done=1; start ignored; exit only via reset.
REQ-024 start asserted in FLUSH, RUN or DONE SHALL have no effect.
REQ-025 Latency: first FLUSH beat SHALL be valid in the cycle after start is sampled.

Reset
REQ-026 On reset: state=IDLE, out_valid=0, out_instr=32'h00000013, out_is_load=0, done=0, count=0, LFSR=SEED (or 1), FLUSH counter=0.
REQ-027 Reset asserted mid-FLUSH or mid-RUN SHALL take priority over a same-cycle transfer; outputs show reset values in the following cycle.
REQ-028 A run restarted after reset SHALL reproduce a bit-identical instruction sequence.

Structure
REQ-029 Package sodor5_stim_pkg SHALL hold: opcodes OP_IMM/OP_LOAD, NOP constant 32'h00000013, shift masks 12'h41F/12'h01F, LFSR taps, and the state enum.
REQ-030 The LFSR SHALL be the sub-module stim_lfsr32 (ports clk, reset, seed, advance, value).
REQ-031 The block SHALL be synthesizable and contain no $urandom or other simulation-only constructs.

Verification
REQ-032 Reset, then 10 idle cycles -> out_valid=0, out_instr=0x00000013, done=0, count=0.
REQ-033 NOP_FLUSH=2, NUM_INSTR=3, out_ready=1, start pulse -> 2 NOP beats, 3 random beats, then done=1, count=3, out_valid=0.
REQ-034 out_ready=0 for 5 cycles mid-RUN -> out_instr and count constant; beat transfers once out_ready=1.
REQ-035 NUM_INSTR=10000, out_ready=1 -> every OP_IMM beat with funct3=1 has instr[31:25]=0; with funct3=5 has instr[31:25] in {0x00,0x20}; every load beat has funct3 in {0,4}; both opcodes appear.
REQ-036 Reset after 2 RUN transfers, then restart -> IDLE next cycle, count=0; new sequence matches the first run beat for beat.
REQ-037 SEED=0 -> LFSR starts at 1; 100 consecutive random words are not all identical.

Source files
------------

// File: rtl/sodor5_stim_pkg.sv
// Shared constants, FSM state type and RV32I field packing for the
// random instruction stimulus generator.
package sodor5_stim_pkg;

  localparam logic [6:0]  OP_IMM        = 7'b0010011;
  localparam logic [6:0]  OP_LOAD       = 7'b0000011;
  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
  localparam logic [11:0] SHIFT_MASK_SR = 12'h41F;
  localparam logic [11:0] SHIFT_MASK_SL = 12'h01F;
  localparam logic [31:0] LFSR_TAPS     = 32'h8020_0003;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Builds either an OP-IMM or a LOAD word from one LFSR snapshot. Shift
  // immediates are masked so SLLI/SRLI/SRAI always decode as legal shifts.
  function automatic logic [31:0] encode_instr(input logic [31:0] l);
    logic [11:0] imm;
    logic [2:0]  funct3;
    funct3 = l[13:11];
    imm    = l[25:14];
    if (funct3 == 3'd5) begin
      imm = imm & SHIFT_MASK_SR;
    end else if (funct3 == 3'd1) begin
      imm = imm & SHIFT_MASK_SL;
    end
    if (l[0]) begin
      return {imm, l[10:6], funct3, l[5:1], OP_IMM};
    end
    return {l[31:20], l[10:6], l[26], 2'b00, l[5:1], OP_LOAD};
  endfunction

endpackage

// File: rtl/stim_lfsr32.sv
// 32-bit right-shifting Galois LFSR; steps once per cycle that advance is high.
module stim_lfsr32
  import sodor5_stim_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] seed,
  input  logic        advance,
  output logic [31:0] value
);

  // An all-zero state would lock the LFSR, so a zero seed becomes 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      value <= (seed == 32'd0) ? 32'd1 : seed;
    end else if (advance) begin
      value <= {1'b0, value[31:1]} ^ (value[0] ? LFSR_TAPS : 32'd0);
    end
  end

endmodule

// File: rtl/instr_stim_gen.sv
// Random RV32I instruction-memory stimulus: NOP flush beats, then NUM_INSTR
// random OP-IMM/LOAD words on a valid/ready stream, then a sticky done.
module instr_stim_gen
  import sodor5_stim_pkg::*;
#(
  parameter logic [31:0] SEED      = 32'd1016,
  parameter int          NUM_INSTR = 100,
  parameter int          NOP_FLUSH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_is_load,
  output logic        done,
  output logic [15:0] count
);

  localparam bit          HAS_FLUSH  = (NOP_FLUSH > 0);
  localparam bit          HAS_RUN    = (NUM_INSTR > 0);
  localparam logic [15:0] FLUSH_LAST = 16'(NOP_FLUSH - 1);
  localparam logic [16:0] RUN_TOTAL  = 17'(NUM_INSTR);

  state_t      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [15:0] count_q, count_d;
  logic [15:0] flush_q, flush_d;
  logic        advance;
  logic        transfer;
  logic [31:0] lfsr_value;
  logic [31:0] rand_word;

  stim_lfsr32 u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .seed    (SEED),
    .advance (advance),
    .value   (lfsr_value)
  );

  assign rand_word = encode_instr(lfsr_value);
  assign out_valid = (state_q == ST_FLUSH) || (state_q == ST_RUN);
  assign transfer  = out_valid && out_ready;

  // NOTE: every signal driven here gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    count_d = count_q;
    flush_d = flush_q;
    advance = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (HAS_FLUSH) begin
            state_d = ST_FLUSH;
            instr_d = NOP_INSTR;
            flush_d = 16'd0;
          end else if (HAS_RUN) begin
            state_d = ST_RUN;
            instr_d = rand_word;
            advance = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_FLUSH: begin
        if (transfer) begin
          if (flush_q == FLUSH_LAST) begin
            if (HAS_RUN) begin
              state_d = ST_RUN;
              instr_d = rand_word;
              advance = 1'b1;
            end else begin
              state_d = ST_DONE;
              instr_d = NOP_INSTR;
            end
          end else begin
            flush_d = flush_q + 16'd1;
          end
        end
      end
      ST_RUN: begin
        if (transfer) begin
          count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
          // The completing beat does not fetch another word, so the LFSR
          // steps exactly NUM_INSTR times per run.
          if (({1'b0, count_q} + 17'd1) == RUN_TOTAL) begin
            state_d = ST_DONE;
            instr_d = NOP_INSTR;
          end else begin
            instr_d = rand_word;
            advance = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
        instr_d = NOP_INSTR;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      instr_q <= NOP_INSTR;
      count_q <= 16'd0;
      flush_q <= 16'd0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      count_q <= count_d;
      flush_q <= flush_d;
    end
  end

  assign out_instr   = instr_q;
  assign out_is_load = (instr_q[6:0] == OP_LOAD);
  assign done        = (state_q == ST_DONE);
  assign count       = count_q;

endmodule
